// File: rtl/inst_fetch_responder.sv
// Instruction-memory responder: returns the word at a fetch PC after LATENCY cycles.
// Optional INST_FETCH_FAULT_EN adds rsp_fault and returns ebreak for misaligned/out-of-range PCs.
//
// state | meaning
// IDLE  | no request in flight, ready to accept
// WAIT  | request accepted, latency counter running down
// RESP  | response presented, held until rsp_ready
module inst_fetch_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_inst,
`ifdef INST_FETCH_FAULT_EN
    output logic                  rsp_fault,
`endif
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_idx,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam logic [3:0]            CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [DATA_WIDTH-1:0] EBREAK   = DATA_WIDTH'(32'h0010_0073);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] rsp_inst_q, rsp_inst_d;
    logic [ADDR_WIDTH-1:0] offset;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  ready;
`ifdef INST_FETCH_FAULT_EN
    logic                  fault_req;
    logic                  hold_fault_q, hold_fault_d;
    logic                  rsp_fault_q, rsp_fault_d;
`endif

    assign offset = req_addr - BASE_ADDR;
    assign idx    = DEPTH_LOG2'(offset >> 2);

`ifdef INST_FETCH_FAULT_EN
    assign fault_req = (req_addr[1:0] != 2'b00) || ((offset >> (DEPTH_LOG2 + 2)) != '0);
    assign rd_word   = fault_req ? EBREAK : mem_q[idx];
`else
    assign rd_word   = mem_q[idx];
`endif

    // Combinational read of the pre-edge array gives read-before-write on a same-edge load.
    always_ff @(posedge clk) begin
        if (!rst && ld_en) begin
            mem_q[ld_idx] <= ld_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        rsp_inst_d = rsp_inst_q;
        ready      = 1'b0;
`ifdef INST_FETCH_FAULT_EN
        hold_fault_d = hold_fault_q;
        rsp_fault_d  = rsp_fault_q;
`endif
        case (state_q)
            ST_IDLE: ready = 1'b1;
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = ST_RESP;
                    rsp_inst_d = hold_q;
`ifdef INST_FETCH_FAULT_EN
                    rsp_fault_d = hold_fault_q;
`endif
                end
            end
            ST_RESP: begin
                ready = rsp_ready;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept overrides the RESP->IDLE exit so back-to-back fetches chain.
        if (req_valid && ready) begin
            hold_d = rd_word;
`ifdef INST_FETCH_FAULT_EN
            hold_fault_d = fault_req;
`endif
            if (LATENCY == 1) begin
                state_d    = ST_RESP;
                cnt_d      = 4'd0;
                rsp_inst_d = rd_word;
`ifdef INST_FETCH_FAULT_EN
                rsp_fault_d = fault_req;
`endif
            end else begin
                state_d = ST_WAIT;
                cnt_d   = CNT_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            hold_q     <= '0;
            rsp_inst_q <= '0;
`ifdef INST_FETCH_FAULT_EN
            hold_fault_q <= 1'b0;
            rsp_fault_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            rsp_inst_q <= rsp_inst_d;
`ifdef INST_FETCH_FAULT_EN
            hold_fault_q <= hold_fault_d;
            rsp_fault_q  <= rsp_fault_d;
`endif
        end
    end

    assign req_ready = ready;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_inst  = rsp_inst_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef INST_FETCH_FAULT_EN
    assign rsp_fault = rsp_fault_q;
`endif

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Bench for inst_fetch_responder: LATENCY=2 (unit 0) and LATENCY=1 (unit 1) against a timing model.
// Honours INST_FETCH_FAULT_EN when defined.
module tb_inst_fetch_responder;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        req_valid [2];
    logic        rsp_ready [2];
    logic        ld_en [2];
    logic [31:0] req_addr [2];
    logic [31:0] ld_data [2];
    logic [9:0]  ld_idx [2];
    logic        req_ready_o [2];
    logic        rsp_valid_o [2];
    logic        busy_o [2];
    logic [31:0] rsp_inst_o [2];
`ifdef INST_FETCH_FAULT_EN
    logic        rsp_fault_o [2];
`endif

    int checks = 0;
    int errors = 0;

    // model state
    logic [31:0] mem_m [2][1024];
    bit          pend [2];
    int          due [2];
    logic [31:0] pword [2];
    bit          pflt [2];
    logic [31:0] shown [2];
    bit          shown_flt [2];
    int          cyc = 0;
    bit          armed = 0;

    always #5 clk = ~clk;

    inst_fetch_responder #(.LATENCY(LAT0)) dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready_o[0]),
        .req_addr(req_addr[0]), .rsp_valid(rsp_valid_o[0]), .rsp_ready(rsp_ready[0]),
        .rsp_inst(rsp_inst_o[0]),
`ifdef INST_FETCH_FAULT_EN
        .rsp_fault(rsp_fault_o[0]),
`endif
        .ld_en(ld_en[0]), .ld_idx(ld_idx[0]), .ld_data(ld_data[0]), .busy(busy_o[0]));

    inst_fetch_responder #(.LATENCY(LAT1)) dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready_o[1]),
        .req_addr(req_addr[1]), .rsp_valid(rsp_valid_o[1]), .rsp_ready(rsp_ready[1]),
        .rsp_inst(rsp_inst_o[1]),
`ifdef INST_FETCH_FAULT_EN
        .rsp_fault(rsp_fault_o[1]),
`endif
        .ld_en(ld_en[1]), .ld_idx(ld_idx[1]), .ld_data(ld_data[1]), .busy(busy_o[1]));

    function automatic logic [31:0] pat(input int i);
        return 32'h1357_0000 + 32'(i) * 32'h0001_0001;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fetch(input int d, input logic [31:0] addr, input logic [31:0] exp, input string nm);
        int n;
        rsp_ready[d] = 1'b1;
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        step();
        req_valid[d] = 1'b0;
        n = 0;
        while (rsp_valid_o[d] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({nm, "_lat"}, 32'(n), 32'((d == 0) ? LAT0 - 1 : LAT1 - 1));
        chk({nm, "_inst"}, rsp_inst_o[d], exp);
        step();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; rsp_ready[d] = 1'b1; ld_en[d] = 1'b0;
            req_addr[d] = BASE; ld_data[d] = '0; ld_idx[d] = '0;
            pend[d] = 0; due[d] = 0; pword[d] = '0; pflt[d] = 0; shown[d] = '0; shown_flt[d] = 0;
        end

        fork
            // model: advances on every edge from the bench's own inputs
            forever begin
                @(posedge clk);
                for (int d = 0; d < 2; d++) begin
                    if (rst[d]) begin
                        pend[d] = 0; shown[d] = '0; shown_flt[d] = 0;
                    end else begin
                        bit rv, rdy, flt;
                        logic [31:0] off, w;
                        rv  = pend[d] && (cyc >= due[d]);
                        rdy = !pend[d] || (rv && rsp_ready[d]);
                        if (rv && rsp_ready[d]) pend[d] = 0;
                        if (req_valid[d] && rdy) begin
                            off = req_addr[d] - BASE;
                            flt = 0;
`ifdef INST_FETCH_FAULT_EN
                            flt = (req_addr[d][1:0] != 2'b00) || (off >= 32'd4096);
`endif
                            w = flt ? EBRK : mem_m[d][(off / 4) % 1024];
                            pend[d] = 1; due[d] = cyc + ((d == 0) ? LAT0 : LAT1);
                            pword[d] = w; pflt[d] = flt;
                        end
                        if (ld_en[d]) mem_m[d][ld_idx[d]] = ld_data[d];
                    end
                end
                if (rst[0] && rst[1]) armed = 1;
                cyc++;
            end
            // compare process
            forever begin
                @(negedge clk);
                if (armed) begin
                    for (int d = 0; d < 2; d++) begin
                        bit rv;
                        rv = pend[d] && (cyc >= due[d]);
                        if (rv) begin
                            shown[d] = pword[d];
                            shown_flt[d] = pflt[d];
                        end
                        chk($sformatf("u%0d_rsp_valid", d), 32'(rsp_valid_o[d]), 32'(rv));
                        chk($sformatf("u%0d_rsp_inst", d), rsp_inst_o[d], shown[d]);
                        chk($sformatf("u%0d_busy", d), 32'(busy_o[d]), 32'(pend[d]));
                        chk($sformatf("u%0d_req_ready", d), 32'(req_ready_o[d]),
                            32'(!pend[d] || (rv && rsp_ready[d])));
`ifdef INST_FETCH_FAULT_EN
                        chk($sformatf("u%0d_rsp_fault", d), 32'(rsp_fault_o[d]), 32'(shown_flt[d]));
`endif
                    end
                end
            end
        join_none

        step();
        step();
        for (int d = 0; d < 2; d++) rst[d] = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid_o[0]), 32'd0);
        chk("rst_rsp_inst", rsp_inst_o[0], 32'd0);
        chk("rst_busy", 32'(busy_o[1]), 32'd0);
        chk("rst_req_ready", 32'(req_ready_o[1]), 32'd1);

        // program load: a pattern everywhere, then the two test words
        for (int i = 0; i < 1024; i++) begin
            for (int d = 0; d < 2; d++) begin
                ld_en[d] = 1'b1; ld_idx[d] = 10'(i);
                ld_data[d] = (i == 0) ? 32'h0010_0093 : (i == 1) ? 32'h0000_0513 : pat(i);
            end
            step();
        end
        for (int d = 0; d < 2; d++) ld_en[d] = 1'b0;

        // LATENCY=2 basic fetch
        rsp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = BASE;
        step();
        req_valid[0] = 1'b0;
        chk("t1_busy_mid", 32'(busy_o[0]), 32'd1);
        chk("t1_valid_mid", 32'(rsp_valid_o[0]), 32'd0);
        step();
        chk("t1_valid", 32'(rsp_valid_o[0]), 32'd1);
        chk("t1_inst", rsp_inst_o[0], 32'h0010_0093);
        step();
        chk("t1_idle", 32'(busy_o[0]), 32'd0);

        // LATENCY=1 back-to-back
        rsp_ready[1] = 1'b1; req_valid[1] = 1'b1; req_addr[1] = BASE;
        step();
        chk("t2_v0", 32'(rsp_valid_o[1]), 32'd1);
        chk("t2_i0", rsp_inst_o[1], 32'h0010_0093);
        chk("t2_rdy", 32'(req_ready_o[1]), 32'd1);
        req_addr[1] = BASE + 32'd4;
        step();
        chk("t2_v1", 32'(rsp_valid_o[1]), 32'd1);
        chk("t2_i1", rsp_inst_o[1], 32'h0000_0513);
        chk("t2_rdy1", 32'(req_ready_o[1]), 32'd1);
        for (int i = 0; i < 8; i++) begin
            req_addr[1] = BASE + 32'(4 * (i + 10));
            step();
            chk("t2_stream", rsp_inst_o[1], pat(i + 10));
        end
        req_valid[1] = 1'b0;
        step();
        chk("t2_end", 32'(rsp_valid_o[1]), 32'd0);

        // backpressure
        rsp_ready[0] = 1'b0; req_valid[0] = 1'b1; req_addr[0] = BASE + 32'd4;
        step();
        req_valid[0] = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid", 32'(rsp_valid_o[0]), 32'd1);
            chk("t3_inst", rsp_inst_o[0], 32'h0000_0513);
            chk("t3_rdy", 32'(req_ready_o[0]), 32'd0);
            step();
        end
        rsp_ready[0] = 1'b1;
        #1;
        chk("t3_rdy_pass", 32'(req_ready_o[0]), 32'd1);
        step();
        chk("t3_done", 32'(rsp_valid_o[0]), 32'd0);
        chk("t3_idle", 32'(busy_o[0]), 32'd0);

        // same-edge load and accept: old word returned, new word stored
        req_valid[0] = 1'b1; req_addr[0] = BASE + 32'd4;
        ld_en[0] = 1'b1; ld_idx[0] = 10'd1; ld_data[0] = 32'hDEAD_BEEF;
        step();
        req_valid[0] = 1'b0; ld_en[0] = 1'b0;
        step();
        chk("t4_old", rsp_inst_o[0], 32'h0000_0513);
        step();
        fetch(0, BASE + 32'd4, 32'hDEAD_BEEF, "t4_new");

        // reset in WAIT; load during reset is ignored
        req_valid[0] = 1'b1; req_addr[0] = BASE;
        step();
        req_valid[0] = 1'b0;
        chk("t5_wait_busy", 32'(busy_o[0]), 32'd1);
        rst[0] = 1'b1; rst[1] = 1'b1;
        ld_en[1] = 1'b1; ld_idx[1] = 10'd5; ld_data[1] = 32'hBAD0_0005;
        step();
        rst[0] = 1'b0; rst[1] = 1'b0; ld_en[1] = 1'b0;
        chk("t5_valid", 32'(rsp_valid_o[0]), 32'd0);
        chk("t5_busy", 32'(busy_o[0]), 32'd0);
        chk("t5_rdy", 32'(req_ready_o[0]), 32'd1);
        fetch(0, BASE, 32'h0010_0093, "t5_after");
        fetch(1, BASE + 32'h14, pat(5), "t5_ldrst");

        // misaligned / out of range
`ifdef INST_FETCH_FAULT_EN
        rsp_ready[1] = 1'b1; req_valid[1] = 1'b1; req_addr[1] = BASE + 32'd2;
        step();
        req_valid[1] = 1'b0;
        chk("t6_mis_fault", 32'(rsp_fault_o[1]), 32'd1);
        chk("t6_mis_inst", rsp_inst_o[1], EBRK);
        step();
        fetch(0, BASE + 32'h1000, EBRK, "t6_oor");
        fetch(1, BASE + 32'h8, pat(2), "t6_ok");
`else
        fetch(0, BASE + 32'h1000, 32'h0010_0093, "t6_alias");
        fetch(1, BASE + 32'd2, 32'h0010_0093, "t6_lowbits");
        fetch(1, BASE - 32'd4, pat(1023), "t6_wrap");
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
